// File: rtl/timer_controller.sv
// Countdown-timer sequencer: mm:ss BCD time, five-state timer FSM driven by
// debounced buttons, and the 1 Hz prescaler that feeds the display painter.
//
// state      | meaning
// INICIAL    | idle, time held at 00:00
// ESTABLECER | setting mode, min/sec buttons edit the time
// CONTANDO   | counting down once per tick
// DETENIDO   | paused, time frozen
// FINAL      | reached 00:00, finish asserted
module timer_controller #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_set,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       btn_min,
  input  logic       btn_sec,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [2:0] actualState,
  output logic       finish,
  output logic       clk1Hz,
  output logic       tick
);

  localparam int PW = $clog2(CLK_HZ);

  typedef enum logic [2:0] {
    INICIAL    = 3'b000,
    ESTABLECER = 3'b001,
    CONTANDO   = 3'b010,
    DETENIDO   = 3'b011,
    FINAL      = 3'b101
  } state_t;

  state_t        state, state_next;
  logic [5:0]    btn, btn_q, ev;
  logic          ev_clear, ev_stop, ev_start, ev_set, ev_min, ev_sec;
  logic [15:0]   t_cur, t_next;
  logic          t_zero, pre_clr;
  logic [PW-1:0] pre, pre_next;

  assign btn = {btn_clear, btn_stop, btn_start, btn_set, btn_min, btn_sec};
  assign ev  = btn & ~btn_q;
  assign {ev_clear, ev_stop, ev_start, ev_set, ev_min, ev_sec} = ev;

  assign t_cur       = {dig0, dig1, dig2, dig3};
  assign t_zero      = (t_cur == 16'h0000);
  assign actualState = state;

  // Two BCD digits counting 00..59 with wrap.
  function automatic logic [7:0] inc60(input logic [3:0] tens, input logic [3:0] units);
    logic [7:0] r;
    if (units == 4'd9) begin
      if (tens == 4'd5) r = 8'h00;
      else              r = {tens + 4'd1, 4'd0};
    end else begin
      r = {tens, units + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else if (t[7:4] != 4'd0) begin
      r[7:0] = {t[7:4] - 4'd1, 4'd9};
    end else if (t[15:8] != 8'h00) begin
      r[7:0] = 8'h59;
      if (t[11:8] != 4'd0) r[11:8]  = t[11:8] - 4'd1;
      else                 r[15:8]  = {t[15:12] - 4'd1, 4'd9};
    end
    return r;
  endfunction

  always_comb begin
    state_next = state;
    t_next     = t_cur;
    pre_clr    = 1'b0;
    case (state)
      INICIAL: begin
        t_next = 16'h0000;
        if (ev_set) state_next = ESTABLECER;
      end
      ESTABLECER: begin
        if (ev_clear) begin
          t_next = 16'h0000;
        end else if (ev_start && !t_zero) begin
          state_next = CONTANDO;
          pre_clr    = 1'b1;
        end else begin
          if (ev_min) t_next[15:8] = inc60(dig0, dig1);
          if (ev_sec) t_next[7:0]  = inc60(dig2, dig3);
        end
      end
      CONTANDO: begin
        if (ev_clear) begin
          state_next = INICIAL;
          t_next     = 16'h0000;
        end else if (ev_stop) begin
          state_next = DETENIDO;
        end else if (tick) begin
          t_next = dec_time(t_cur);
          if (t_next == 16'h0000) state_next = FINAL;
        end
      end
      DETENIDO: begin
        if (ev_clear) begin
          state_next = INICIAL;
          t_next     = 16'h0000;
        end else if (ev_start) begin
          state_next = CONTANDO;
          pre_clr    = 1'b1;
        end else if (ev_set) begin
          state_next = ESTABLECER;
        end
      end
      FINAL: begin
        t_next = 16'h0000;
        if (ev_clear || ev_set) state_next = INICIAL;
      end
      default: begin
        state_next = INICIAL;
        t_next     = 16'h0000;
      end
    endcase
  end

  // tick/clk1Hz are decoded from the next prescaler value so they stay registered.
  always_comb begin
    if (pre_clr || pre == PW'(CLK_HZ - 1)) pre_next = '0;
    else                                   pre_next = pre + PW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= INICIAL;
      dig0   <= 4'd0;
      dig1   <= 4'd0;
      dig2   <= 4'd0;
      dig3   <= 4'd0;
      btn_q  <= 6'b0;
      pre    <= '0;
      tick   <= 1'b0;
      clk1Hz <= 1'b1;
      finish <= 1'b0;
    end else begin
      state                  <= state_next;
      {dig0, dig1, dig2, dig3} <= t_next;
      btn_q                  <= btn;
      pre                    <= pre_next;
      tick                   <= (pre_next == PW'(CLK_HZ - 1));
      clk1Hz                 <= (pre_next < PW'(CLK_HZ / 2));
      finish                 <= (state_next == FINAL);
    end
  end

endmodule

// File: doc/timer_controller.md
# timer_controller

Sequencing controller for the VGA countdown-timer display. Holds the mm:ss countdown value in BCD, runs the five-state timer FSM (Inicial, Establecer, Contando, Detenido, Final) from debounced push-buttons, and generates the 1 Hz timebase. Drives the text painter's `dig0..dig3`, `actualState`, `finish` and `clk1Hz` inputs directly.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per second. Minimum 4; even values only. Benches use 10.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_set`  in  1  debounced level; enter or return to setting mode.
- `btn_start`  in  1  debounced level; start or resume the countdown.
- `btn_stop`  in  1  debounced level; pause the countdown.
- `btn_clear`  in  1  debounced level; clear the time or return to Inicial.
- `btn_min`  in  1  debounced level; increment minutes (Establecer only).
- `btn_sec`  in  1  debounced level; increment seconds (Establecer only).
- `dig0`  out  4  minutes tens, BCD.
- `dig1`  out  4  minutes units, BCD.
- `dig2`  out  4  seconds tens, BCD.
- `dig3`  out  4  seconds units, BCD.
- `actualState`  out  3  state code, listed under Operation.
- `finish`  out  1  high while in Final.
- `clk1Hz`  out  1  1 Hz square wave, 50 % duty.
- `tick`  out  1  one-cycle pulse, once per second.

## Operation
- **Button edges:** each `btn_*` is registered into `btn_q`. The event is `btn & ~btn_q`. A held button produces exactly one event.
- **Event priority** (same cycle): clear > stop > start > set > min/sec. Only the highest-priority event that is legal in the current state acts; the rest are dropped.
- **State codes:** INICIAL=3'b000, ESTABLECER=3'b001, CONTANDO=3'b010, DETENIDO=3'b011, FINAL=3'b101. Unused codes (100, 110, 111) go to INICIAL on the next edge with time cleared.
- **INICIAL:** time is 00:00.
  - set -> ESTABLECER.
  - All other events are ignored.
- **ESTABLECER:**
  - min: minutes +1, BCD, 59 wraps to 00.
  - sec: seconds +1, BCD, 59 wraps to 00. No carry into minutes.
  - clear: time -> 00:00, state stays ESTABLECER.
  - start with time != 00:00 -> CONTANDO. Start with 00:00 is ignored.
- **CONTANDO:**
  - On `tick`, decrement time by 1 s. Seconds 00 borrows: seconds -> 59, minutes -1.
  - A decrement that yields 00:00 -> FINAL in the same edge.
  - stop -> DETENIDO. clear -> INICIAL, time 00:00. set is ignored.
- **DETENIDO:** time frozen.
  - start -> CONTANDO.
  - set -> ESTABLECER, time kept.
  - clear -> INICIAL, time 00:00.
- **FINAL:** time stays 00:00.
  - clear or set -> INICIAL.
  - start, stop, min and sec are ignored.
- **BCD invariant:** `dig0` 0–5, `dig1` 0–9, `dig2` 0–5, `dig3` 0–9 at all times. No binary intermediate is exposed.
- **Prescaler:** counter `pre` runs 0..CLK_HZ-1 and wraps.
  - `tick` = (`pre` == CLK_HZ-1).
  - `clk1Hz` = (`pre` < CLK_HZ/2).
  - `pre` is forced to 0 on the edge that enters CONTANDO, both from ESTABLECER and from DETENIDO.

## Timing
- **Reset values** (asynchronous, `reset_n`=0):
  - state INICIAL, `actualState`=000.
  - `dig0..dig3`=0, `finish`=0, `tick`=0.
  - `pre`=0, so `clk1Hz`=1.
  - `btn_q`=0.
- **Reset release:** a button already high when reset releases counts as an event on the first edge.
- **Registered outputs:** all outputs, including `tick` and `finish`, are registered.
- **Button latency:** button sampled high at edge k, low at k-1 -> state and digit changes are visible after edge k.
- **Countdown timing:** the first decrement is visible CLK_HZ edges after the edge that entered CONTANDO. Later decrements follow every CLK_HZ edges.
- **Tick pulse:** `tick` is high for exactly 1 cycle per CLK_HZ cycles, in every state.
- **stop and tick together:** stop wins and no decrement occurs.
- **clear and tick together:** clear wins.
- **finish:** rises on the same edge that enters FINAL and falls on the edge that leaves FINAL.
- **Reset mid-count:** all state is lost immediately and the block behaves as after reset.

## Test plan
- **Reset:** reset with CLK_HZ=10, release, observe 25 cycles -> `actualState`=000, digits 0000, `finish`=0, `tick` pulses every 10 cycles, `clk1Hz` high 5 / low 5.
- **Setting wrap:** set, 61× min, 3× sec -> ESTABLECER, digits 0,1,0,3 (61 mod 60 = 01). A second clear -> 0000.
- **Countdown and finish:** set 00:02, start -> 00:01 after 10 cycles, FINAL with `finish`=1 after 20 cycles. clear -> INICIAL, `finish`=0 next edge.
- **Borrow:** set 01:00, start, 1 tick -> 00:59.
- **Pause and resume:** pause at 00:05, hold 35 cycles, still 00:05. start -> 00:04 exactly 10 cycles later.
- **Priority and edge cases:**
  - Start with 00:00 -> stays ESTABLECER.
  - stop and start in the same cycle while in CONTANDO -> DETENIDO.
  - stop coincident with `tick` -> no decrement.
  - Button held 50 cycles -> single increment.
  - Assert `reset_n` low mid-count at 00:07 -> immediate 000 / 0000.
